// File: rtl/mc_core_pkg.sv
// Shared definitions for mc_core: opcodes, FSM state encoding, flag bit positions.
package mc_core_pkg;
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_MOV  = 5'b00001;
    localparam logic [4:0] OP_MOVI = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_CMP  = 5'b01001;
    localparam logic [4:0] OP_LD   = 5'b01010;
    localparam logic [4:0] OP_ST   = 5'b01011;
    localparam logic [4:0] OP_JMP  = 5'b01100;
    localparam logic [4:0] OP_JZ   = 5'b01101;
    localparam logic [4:0] OP_JNZ  = 5'b01110;
    localparam logic [4:0] OP_JL   = 5'b01111;
    localparam logic [4:0] OP_JG   = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    localparam int FLG_Z  = 0;
    localparam int FLG_L  = 1;
    localparam int FLG_G  = 2;
    localparam int NREGS  = 4;
    localparam int REG_AW = 2;
endpackage

// File: rtl/mc_core_if.sv
// Program-load, run control and debug/status bundle between the board top and mc_core.
interface mc_core_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic              prog_we;
    logic [PC_W-1:0]   prog_addr;
    logic [15:0]       prog_data;
    logic              run;
    logic [1:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_reg;
    logic [2:0]        flags;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              halted;
    logic              illegal;

    modport master (
        output prog_we, prog_addr, prog_data, run, dbg_sel,
        input  dbg_reg, flags, pc, busy, halted, illegal
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, run, dbg_sel,
        output dbg_reg, flags, pc, busy, halted, illegal
    );
endinterface

// File: rtl/mc_core_regfile.sv
// 4-entry register file: two async read ports, one sync write port, async debug read.
module mc_core_regfile
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra,
    input  logic [REG_AW-1:0] i_rb,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [REG_AW-1:0] i_dbg_sel,
    output logic [DATA_W-1:0] o_ra_dat,
    output logic [DATA_W-1:0] o_rb_dat,
    output logic [DATA_W-1:0] o_dbg_dat
);
    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_ra_dat  = r_regs[i_ra];
    assign o_rb_dat  = r_regs[i_rb];
    assign o_dbg_dat = r_regs[i_dbg_sel];
endmodule

// File: rtl/mc_core.sv
// Multicycle 16-bit-ISA core with internal IMEM/DMEM: 2 cycles per instruction, 3 for LD.
// prog_we aborts execution to IDLE at any time; run is honoured only in IDLE or HALT.
module mc_core
    import mc_core_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 8
) (
    input  logic     clk,
    input  logic     reset,
    mc_core_if.slave bus
);
    state_t             r_state, w_state_nxt;
    logic [PC_W-1:0]    r_pc, w_pc_nxt;
    logic [15:0]        r_ir;
    logic [2:0]         r_flags, w_flags_nxt;
    logic               r_illegal;
    logic [DATA_W-1:0]  r_ld_q;
    logic [15:0]        r_imem [2**PC_W];
    logic [DATA_W-1:0]  r_dmem [2**DMEM_AW];

    logic [4:0]         w_op;
    logic [1:0]         w_rd, w_rs;
    logic [DATA_W-1:0]  w_imm, w_a, w_b, w_res, w_rf_wd;
    logic [PC_W-1:0]    w_tgt;
    logic [DMEM_AW-1:0] w_daddr;
    logic               w_wr, w_fl_we, w_jmp, w_halt_op, w_ill;
    logic               w_rf_we, w_exec, w_pc_last, w_unused;

    assign w_op      = r_ir[15:11];
    assign w_rd      = r_ir[10:9];
    assign w_rs      = r_ir[8:7];
    assign w_imm     = DATA_W'(r_ir[8:1]);
    assign w_tgt     = PC_W'(r_ir[10:3]);
    assign w_unused  = r_ir[0];
    assign w_exec    = (r_state == ST_EXEC);
    assign w_pc_last = (r_pc == {PC_W{1'b1}});
    assign w_daddr   = w_b[DMEM_AW-1:0];

    always_comb begin
        w_res       = '0;
        w_wr        = 1'b0;
        w_fl_we     = 1'b0;
        w_jmp       = 1'b0;
        w_halt_op   = 1'b0;
        w_ill       = 1'b0;
        w_flags_nxt = '0;
        case (w_op)
            OP_NOP, OP_LD, OP_ST: ;
            OP_MOV:  begin w_res = w_b;         w_wr = 1'b1; end
            OP_MOVI: begin w_res = w_imm;       w_wr = 1'b1; end
            OP_ADD:  begin w_res = w_a + w_b;   w_wr = 1'b1; w_fl_we = 1'b1; end
            OP_SUB:  begin w_res = w_a - w_b;   w_wr = 1'b1; w_fl_we = 1'b1; end
            OP_AND:  begin w_res = w_a & w_b;   w_wr = 1'b1; w_fl_we = 1'b1; end
            OP_OR:   begin w_res = w_a | w_b;   w_wr = 1'b1; w_fl_we = 1'b1; end
            OP_XOR:  begin w_res = w_a ^ w_b;   w_wr = 1'b1; w_fl_we = 1'b1; end
            OP_ADDI: begin w_res = w_a + w_imm; w_wr = 1'b1; w_fl_we = 1'b1; end
            OP_CMP:  begin w_res = w_a - w_b;   w_fl_we = 1'b1; end
            OP_JMP:  w_jmp = 1'b1;
            OP_JZ:   w_jmp = r_flags[FLG_Z];
            OP_JNZ:  w_jmp = !r_flags[FLG_Z];
            OP_JL:   w_jmp = r_flags[FLG_L];
            OP_JG:   w_jmp = r_flags[FLG_G];
            OP_HALT: w_halt_op = 1'b1;
            default: w_ill = 1'b1;
        endcase
        w_flags_nxt[FLG_Z] = (w_res == '0);
        // Only the subtract-style ops report ordering; other flag writers clear L and G.
        if (w_op == OP_SUB || w_op == OP_CMP) begin
            w_flags_nxt[FLG_L] = (w_a < w_b);
            w_flags_nxt[FLG_G] = (w_a > w_b);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (bus.prog_we) begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (bus.run) begin
                        w_state_nxt = ST_FETCH;
                        w_pc_nxt    = '0;
                    end
                end
                ST_FETCH: w_state_nxt = ST_EXEC;
                ST_EXEC: begin
                    if (w_op == OP_LD) begin
                        w_state_nxt = ST_MEM;
                    end else if (w_jmp) begin
                        w_state_nxt = ST_FETCH;
                        w_pc_nxt    = w_tgt;
                    end else if (w_halt_op || w_pc_last) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_pc_nxt    = r_pc + 1'b1;
                    end
                end
                ST_MEM: begin
                    w_state_nxt = w_pc_last ? ST_HALT : ST_FETCH;
                    w_pc_nxt    = w_pc_last ? r_pc : r_pc + 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_rf_we = !bus.prog_we && ((w_exec && w_wr) || r_state == ST_MEM);
    assign w_rf_wd = (r_state == ST_MEM) ? r_ld_q : w_res;

    mc_core_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk       (clk),
        .rst       (reset),
        .i_ra      (w_rd),
        .i_rb      (w_rs),
        .i_we      (w_rf_we),
        .i_wa      (w_rd),
        .i_wd      (w_rf_wd),
        .i_dbg_sel (bus.dbg_sel),
        .o_ra_dat  (w_a),
        .o_rb_dat  (w_b),
        .o_dbg_dat (bus.dbg_reg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (bus.prog_we) begin
                r_illegal <= 1'b0;
            end else begin
                if (r_state == ST_FETCH) r_ir <= r_imem[r_pc];
                if (w_exec && w_fl_we)   r_flags <= w_flags_nxt;
                if (w_exec && w_ill)     r_illegal <= 1'b1;
            end
        end
    end

    // Memories are not reset; an ST is lost under reset because r_state leaves EXEC asynchronously.
    always_ff @(posedge clk) begin
        if (bus.prog_we) r_imem[bus.prog_addr] <= bus.prog_data;
        if (w_exec && !bus.prog_we && w_op == OP_ST) r_dmem[w_daddr] <= w_a;
        if (w_exec && w_op == OP_LD) r_ld_q <= r_dmem[w_daddr];
    end

    assign bus.pc      = r_pc;
    assign bus.flags   = r_flags;
    assign bus.busy    = (r_state == ST_FETCH) || w_exec || (r_state == ST_MEM);
    assign bus.halted  = (r_state == ST_HALT);
    assign bus.illegal = r_illegal;
endmodule

// File: tb/tb_mc_core.sv
// Scoreboard bench for mc_core: directed programs push expectations, a monitor pops and compares.
module tb_mc_core;
    import mc_core_pkg::*;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int K_REG = 0, K_FLAGS = 1, K_PC = 2, K_BUSY = 3, K_HALT = 4, K_ILL = 5, K_MEAS = 6;

    typedef struct {
        string       name;
        int          kind;
        int          sel;
        logic [31:0] act;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int run_cycles;
    int pc_cyc [16];
    logic [15:0] prog [16];

    mc_core_if #(.DATA_W(DW), .PC_W(PW)) bus ();

    mc_core #(.DATA_W(DW), .PC_W(PW), .DMEM_AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc_rr(input logic [4:0] op, input int rd, input int rs);
        return {op, 2'(rd), 2'(rs), 7'b0};
    endfunction

    function automatic logic [15:0] enc_imm(input logic [4:0] op, input int rd, input int imm);
        return {op, 2'(rd), 8'(imm), 1'b0};
    endfunction

    function automatic logic [15:0] enc_jmp(input logic [4:0] op, input int tgt);
        return {op, 8'(tgt), 3'b0};
    endfunction

    task automatic expect_val(input string name, input int kind, input int sel,
                              input logic [31:0] val, input logic [31:0] act);
        exp_t e;
        e.name = name; e.kind = kind; e.sel = sel; e.val = val; e.act = act;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d checks still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.prog_we   = 1'b1;
            bus.prog_addr = PW'(i);
            bus.prog_data = prog[i];
        end
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic run_prog(input int max_cyc);
        @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        run_cycles = 0;
        foreach (pc_cyc[i]) pc_cyc[i] = 0;
        while (!bus.halted && run_cycles < max_cyc) begin
            if (bus.busy) pc_cyc[bus.pc] = pc_cyc[bus.pc] + 1;
            @(negedge clk);
            run_cycles++;
        end
        if (!bus.halted) begin
            n_chk++; n_fail++;
            $display("FAIL run_timeout: halted=%0b after %0d cycles, required 1", bus.halted, run_cycles);
        end
    endtask

    task automatic expect_reset_state(input string tag);
        for (int r = 0; r < 4; r++) expect_val({tag, "_reg"}, K_REG, r, 0, 0);
        expect_val({tag, "_pc"},      K_PC,    0, 0, 0);
        expect_val({tag, "_flags"},   K_FLAGS, 0, 0, 0);
        expect_val({tag, "_busy"},    K_BUSY,  0, 0, 0);
        expect_val({tag, "_halted"},  K_HALT,  0, 0, 0);
        expect_val({tag, "_illegal"}, K_ILL,   0, 0, 0);
    endtask

    // Monitor: one comparison per falling edge, debug select driven here only.
    initial begin
        exp_t e;
        logic [31:0] got;
        bus.dbg_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                bus.dbg_sel = 2'(e.sel);
                #1;
                case (e.kind)
                    K_REG:   got = 32'(bus.dbg_reg);
                    K_FLAGS: got = 32'(bus.flags);
                    K_PC:    got = 32'(bus.pc);
                    K_BUSY:  got = 32'(bus.busy);
                    K_HALT:  got = 32'(bus.halted);
                    K_ILL:   got = 32'(bus.illegal);
                    default: got = e.act;
                endcase
                n_chk++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s (sel %0d): got 0x%0h, required 0x%0h", e.name, e.sel, got, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.run       = 1'b0;

        repeat (2) @(negedge clk);
        expect_reset_state("rst");
        drain();
        reset = 1'b0;

        // 5 - 3 leaves 2 with only G set; four instructions take eight cycles
        prog[0] = enc_imm(OP_MOVI, 0, 5);
        prog[1] = enc_imm(OP_MOVI, 1, 3);
        prog[2] = enc_rr(OP_SUB, 0, 1);
        prog[3] = enc_rr(OP_HALT, 0, 0);
        load(4);
        run_prog(50);
        expect_val("t1_cycles", K_MEAS, 0, 8, 32'(run_cycles));
        expect_val("t1_r0", K_REG, 0, 8'h02, 0);
        expect_val("t1_r1", K_REG, 1, 8'h03, 0);
        expect_val("t1_flags", K_FLAGS, 0, 3'b100, 0);
        expect_val("t1_halted", K_HALT, 0, 1, 0);
        expect_val("t1_pc", K_PC, 0, 3, 0);
        drain();

        // Count-up loop: JL taken twice, falls through when r0 == r1
        prog[0] = enc_imm(OP_MOVI, 0, 0);
        prog[1] = enc_imm(OP_MOVI, 1, 3);
        prog[2] = enc_imm(OP_ADDI, 0, 1);
        prog[3] = enc_rr(OP_CMP, 0, 1);
        prog[4] = enc_jmp(OP_JL, 2);
        prog[5] = enc_rr(OP_HALT, 0, 0);
        load(6);
        run_prog(100);
        expect_val("t2_r0", K_REG, 0, 8'h03, 0);
        expect_val("t2_flags", K_FLAGS, 0, 3'b001, 0);
        expect_val("t2_pc", K_PC, 0, 5, 0);
        drain();

        // Store then load through the same address
        prog[0] = enc_imm(OP_MOVI, 2, 8'hA5);
        prog[1] = enc_imm(OP_MOVI, 3, 7);
        prog[2] = enc_rr(OP_ST, 2, 3);
        prog[3] = enc_rr(OP_LD, 1, 3);
        prog[4] = enc_rr(OP_HALT, 0, 0);
        load(5);
        run_prog(100);
        expect_val("t3_r1", K_REG, 1, 8'hA5, 0);
        expect_val("t3_r2", K_REG, 2, 8'hA5, 0);
        expect_val("t3_ld_cycles", K_MEAS, 0, 3, 32'(pc_cyc[3]));
        expect_val("t3_st_cycles", K_MEAS, 0, 2, 32'(pc_cyc[2]));
        expect_val("t3_total", K_MEAS, 0, 11, 32'(run_cycles));
        drain();

        // All NOPs: PC must stop at the last address instead of wrapping
        foreach (prog[i]) prog[i] = enc_rr(OP_NOP, 0, 0);
        load(16);
        run_prog(100);
        expect_val("t4_cycles", K_MEAS, 0, 32, 32'(run_cycles));
        repeat (3) @(negedge clk);
        expect_val("t4_pc", K_PC, 0, 15, 0);
        expect_val("t4_halted", K_HALT, 0, 1, 0);
        expect_val("t4_busy", K_BUSY, 0, 0, 0);
        drain();

        // Undefined opcode acts as NOP but sets the sticky flag
        prog[0] = enc_rr(5'b10101, 0, 1);
        prog[1] = enc_rr(OP_HALT, 0, 0);
        load(2);
        run_prog(50);
        expect_val("t5_illegal", K_ILL, 0, 1, 0);
        expect_val("t5_r0", K_REG, 0, 8'h03, 0);
        expect_val("t5_r1", K_REG, 1, 8'hA5, 0);
        expect_val("t5_pc", K_PC, 0, 1, 0);
        drain();
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = PW'(5);
        bus.prog_data = enc_rr(OP_NOP, 0, 0);
        @(negedge clk);
        bus.prog_we = 1'b0;
        expect_val("t5_ill_clr", K_ILL, 0, 0, 0);
        expect_val("t5_pc_clr", K_PC, 0, 0, 0);
        expect_val("t5_idle_busy", K_BUSY, 0, 0, 0);
        expect_val("t5_idle_halt", K_HALT, 0, 0, 0);
        expect_val("t5_flags_kept", K_FLAGS, 0, 3'b001, 0);
        drain();

        // Reset asserted while ADD sits in EXEC
        prog[0] = enc_imm(OP_MOVI, 0, 1);
        prog[1] = enc_imm(OP_MOVI, 1, 2);
        prog[2] = enc_rr(OP_ADD, 0, 1);
        prog[3] = enc_rr(OP_HALT, 0, 0);
        load(4);
        @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        repeat (5) @(negedge clk);
        expect_val("t6_pre_pc", K_MEAS, 0, 2, 32'(bus.pc));
        expect_val("t6_pre_busy", K_MEAS, 0, 1, 32'(bus.busy));
        reset = 1'b1;
        #1;
        expect_reset_state("t6_rst");
        drain();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        expect_val("t6_r0_after", K_REG, 0, 0, 0);
        expect_val("t6_pc_after", K_PC, 0, 0, 0);
        expect_val("t6_busy_after", K_BUSY, 0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
